// File: rtl/pid_pkg.sv
// Constants and the saturation helper shared by the heading-control PID stages.
package pid_pkg;

  localparam logic [4:0] P_COEFF = 5'h08;
  // The D stage applies this coefficient; it is kept here so both stages read one source.
  localparam logic [5:0] D_COEFF = 6'h0B;

  localparam int ERR_W   = 10;
  localparam int DTERM_W = 13;
  localparam int SPD_W   = 12;
  localparam int PTERM_W = 14;
  localparam int ITERM_W = 12;
  localparam int PSUM_W  = 15;

  // Clamp a signed value to the range of a signed field of the given width (width < 16).
  function automatic logic signed [15:0] sat_signed(input logic signed [15:0] value,
                                                    input int width);
    logic signed [15:0] hi;
    logic signed [15:0] lo;
    hi = (16'sd1 <<< (width - 1)) - 16'sd1;
    lo = -hi - 16'sd1;
    if (value > hi)
      sat_signed = hi;
    else if (value < lo)
      sat_signed = lo;
    else
      sat_signed = value;
  endfunction

endpackage

// File: rtl/pid_integrator.sv
// Heading-error integrator: accumulates err_sat on each valid sample, holds on
// overflow and clears whenever the robot is not moving.
module pid_integrator #(
  parameter int INT_W   = 16,
  parameter int I_SHIFT = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic signed [pid_pkg::ERR_W-1:0]   err_sat,
  input  logic                               hdng_vld,
  input  logic                               moving,
  output logic signed [pid_pkg::ITERM_W-1:0] i_term
);
  import pid_pkg::*;

  logic signed [INT_W-1:0] integ_q;
  logic signed [INT_W-1:0] integ_d;
  logic signed [INT_W-1:0] err_ext;
  logic signed [INT_W-1:0] sum;
  logic                    ovf;

  assign err_ext = {{(INT_W - ERR_W){err_sat[ERR_W-1]}}, err_sat};
  assign sum     = integ_q + err_ext;
  // Same-sign operands producing an opposite-sign result means the add wrapped.
  assign ovf     = (integ_q[INT_W-1] == err_ext[INT_W-1]) &&
                   (sum[INT_W-1] != integ_q[INT_W-1]);

  always_comb begin
    integ_d = integ_q;
    if (!moving)
      integ_d = '0;
    else if (hdng_vld && !ovf)
      integ_d = sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      integ_q <= '0;
    else
      integ_q <= integ_d;
  end

  assign i_term = ITERM_W'(integ_q >>> I_SHIFT);

endmodule

// File: rtl/pid_mix.sv
// PID heading mixer: saturates the error for the D stage, sums P+I+D and mixes it with
// forward speed into registered wheel commands. Define PID_PIPE_EN to register PID_div/moving.
module pid_mix #(
  parameter logic [4:0] P_COEFF = pid_pkg::P_COEFF,
  parameter int         INT_W   = 16,
  parameter int         I_SHIFT = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic signed [11:0]                 error,
  input  logic                               hdng_vld,
  input  logic                               moving,
  input  logic        [10:0]                 frwrd_spd,
  input  logic signed [pid_pkg::DTERM_W-1:0] D_term,
  output logic signed [pid_pkg::ERR_W-1:0]   err_sat,
  output logic signed [pid_pkg::SPD_W-1:0]   lft_spd,
  output logic signed [pid_pkg::SPD_W-1:0]   rght_spd
);
  import pid_pkg::*;

  logic signed [PTERM_W-1:0] p_term;
  logic signed [ITERM_W-1:0] i_term;
  logic signed [PSUM_W-1:0]  pid_sum;
  logic signed [11:0]        pid_div;
  logic signed [11:0]        div_eff;
  logic                      mov_eff;
  logic signed [12:0]        lft_raw;
  logic signed [12:0]        rght_raw;
  logic signed [SPD_W-1:0]   lft_sat;
  logic signed [SPD_W-1:0]   rght_sat;
  logic signed [SPD_W-1:0]   lft_q;
  logic signed [SPD_W-1:0]   rght_q;

  assign err_sat = ERR_W'(sat_signed({{4{error[11]}}, error}, ERR_W));

  pid_integrator #(
    .INT_W   (INT_W),
    .I_SHIFT (I_SHIFT)
  ) u_integ (
    .clk      (clk),
    .rst_n    (rst_n),
    .err_sat  (err_sat),
    .hdng_vld (hdng_vld),
    .moving   (moving),
    .i_term   (i_term)
  );

  assign p_term  = $signed({{(PTERM_W - ERR_W){err_sat[ERR_W-1]}}, err_sat}) *
                   $signed({{(PTERM_W - 5){1'b0}}, P_COEFF});
  assign pid_sum = $signed({p_term[PTERM_W-1], p_term}) +
                   $signed({{(PSUM_W - ITERM_W){i_term[ITERM_W-1]}}, i_term}) +
                   $signed({{(PSUM_W - DTERM_W){D_term[DTERM_W-1]}}, D_term});
  assign pid_div = 12'(pid_sum >>> 3);

`ifdef PID_PIPE_EN
  logic signed [11:0] pid_div_q;
  logic               moving_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pid_div_q <= '0;
      moving_q  <= 1'b0;
    end else begin
      pid_div_q <= pid_div;
      moving_q  <= moving;
    end
  end

  assign div_eff = pid_div_q;
  assign mov_eff = moving_q;
`else
  assign div_eff = pid_div;
  assign mov_eff = moving;
`endif

  assign lft_raw  = $signed({2'b00, frwrd_spd}) + $signed({div_eff[11], div_eff});
  assign rght_raw = $signed({2'b00, frwrd_spd}) - $signed({div_eff[11], div_eff});
  assign lft_sat  = SPD_W'(sat_signed({{3{lft_raw[12]}}, lft_raw}, SPD_W));
  assign rght_sat = SPD_W'(sat_signed({{3{rght_raw[12]}}, rght_raw}, SPD_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q  <= '0;
      rght_q <= '0;
    end else begin
      lft_q  <= mov_eff ? lft_sat  : '0;
      rght_q <= mov_eff ? rght_sat : '0;
    end
  end

  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;

endmodule

// File: tb/tb_pid_mix.sv
// Scoreboard bench for pid_mix: a behavioural model predicts each cycle's wheel
// commands, which are queued at drive time and compared after the clock edge.
module tb_pid_mix;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [11:0] error;
  logic               hdng_vld;
  logic               moving;
  logic        [10:0] frwrd_spd;
  logic signed [12:0] D_term;
  logic signed [9:0]  err_sat;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;

  int checks   = 0;
  int failures = 0;

  // Model state: integrator and optional pipeline stage
  int integ_m  = 0;
  int div_q_m  = 0;
  int mov_q_m  = 0;

  typedef struct {
    int lft;
    int rght;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pid_mix dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .error     (error),
    .hdng_vld  (hdng_vld),
    .moving    (moving),
    .frwrd_spd (frwrd_spd),
    .D_term    (D_term),
    .err_sat   (err_sat),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int clamp(int v, int lo, int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int div_model(int es, int integ, int d);
    int sum;
    sum = es * 8 + (integ >>> 4) + d;
    return sum >>> 3;
  endfunction

  // One clock of stimulus: drive, check err_sat, predict, clock, compare.
  task automatic cycle(int e, bit vld, bit mov, int fs, int d);
    exp_t x;
    exp_t got;
    int es, dv, deff, nxt;
    bit meff;
    error     = 12'(e);
    hdng_vld  = vld;
    moving    = mov;
    frwrd_spd = 11'(fs);
    D_term    = 13'(d);
    es = clamp(e, -512, 511);
    #1;
    checks++;
    if (int'(err_sat) !== es) begin
      failures++;
      $display("FAIL err_sat error=%0d got=%0d exp=%0d", e, err_sat, es);
    end
    dv = div_model(es, integ_m, d);
`ifdef PID_PIPE_EN
    deff = div_q_m;
    meff = (mov_q_m != 0);
    div_q_m = dv;
    mov_q_m = mov;
`else
    deff = dv;
    meff = mov;
`endif
    x.lft  = meff ? clamp(fs + deff, -2048, 2047) : 0;
    x.rght = meff ? clamp(fs - deff, -2048, 2047) : 0;
    if (!mov)
      integ_m = 0;
    else if (vld) begin
      nxt = integ_m + es;
      if (nxt <= 32767 && nxt >= -32768) integ_m = nxt;
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty");
    end else begin
      got = sb.pop_front();
      if (int'(lft_spd) !== got.lft || int'(rght_spd) !== got.rght) begin
        failures++;
        $display("FAIL wheel_spd err=%0d vld=%0b mov=%0b fs=%0d d=%0d got=%0d/%0d exp=%0d/%0d",
                 e, vld, mov, fs, d, lft_spd, rght_spd, got.lft, got.rght);
      end else begin
        $display("txn err=%0d vld=%0b mov=%0b fs=%0d d=%0d lft=%0d rght=%0d",
                 e, vld, mov, fs, d, lft_spd, rght_spd);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    error = 12'sd100; hdng_vld = 1'b1; moving = 1'b1; frwrd_spd = 11'd300; D_term = '0;
    #2;
    checks++;
    if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0) begin
      failures++;
      $display("FAIL reset_state got=%0d/%0d exp=0/0", lft_spd, rght_spd);
    end
    @(posedge clk);
    #1;
    checks++;
    if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0) begin
      failures++;
      $display("FAIL reset_held got=%0d/%0d exp=0/0", lft_spd, rght_spd);
    end
    rst_n = 1'b1;
    cycle(0, 0, 0, 300, 0);
  endtask

  task automatic test_saturation();
    cycle(2047, 0, 0, 0, 0);
    checks++;
    if (err_sat !== 10'h1FF) begin
      failures++;
      $display("FAIL sat_pos got=%h exp=1ff", err_sat);
    end
    cycle(-2048, 0, 0, 0, 0);
    checks++;
    if (err_sat !== 10'h200) begin
      failures++;
      $display("FAIL sat_neg got=%h exp=200", err_sat);
    end
    cycle(291, 0, 0, 0, 0);
    checks++;
    if (err_sat !== 10'h123) begin
      failures++;
      $display("FAIL sat_pass got=%h exp=123", err_sat);
    end
  endtask

  task automatic test_integration();
    cycle(0, 0, 0, 1024, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(100, 1, 1, 1024, 0);
      cycle(100, 0, 1, 1024, 0);
    end
    cycle(0, 0, 1, 1024, 0);
    cycle(0, 0, 1, 1024, 0);
    // I_term=100 alone gives PID_div=12
    checks++;
    if (lft_spd !== 12'sd1036 || rght_spd !== 12'sd1012) begin
      failures++;
      $display("FAIL integ_1600 got=%0d/%0d exp=1036/1012", lft_spd, rght_spd);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    checks++;
    if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0) begin
      failures++;
      $display("FAIL reset_async got=%0d/%0d exp=0/0", lft_spd, rght_spd);
    end
    integ_m = 0; div_q_m = 0; mov_q_m = 0;
    sb.delete();
    #2;
    rst_n = 1'b1;
    cycle(0, 0, 0, 1024, 0);
    cycle(0, 0, 0, 1024, 0);
    checks++;
    if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0) begin
      failures++;
      $display("FAIL reset_idle got=%0d/%0d exp=0/0", lft_spd, rght_spd);
    end
    cycle(0, 0, 1, 1024, 0);
    cycle(0, 0, 1, 1024, 0);
    checks++;
    if (lft_spd !== 12'sd1024 || rght_spd !== 12'sd1024) begin
      failures++;
      $display("FAIL reset_integ_zero got=%0d/%0d exp=1024/1024", lft_spd, rght_spd);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 70; i++)
      cycle(2047, 1, 1, 0, 0);
    cycle(0, 0, 1, 1024, 0);
    cycle(0, 0, 1, 1024, 0);
    // integ held at 32704 -> I_term=2044 -> PID_div=255
    checks++;
    if (lft_spd !== 12'sd1279 || rght_spd !== 12'sd769) begin
      failures++;
      $display("FAIL overflow_hold got=%0d/%0d exp=1279/769", lft_spd, rght_spd);
    end
  endtask

  task automatic test_mixing();
    cycle(0, 0, 0, 512, 0);
    cycle(64, 0, 1, 512, 0);
    cycle(64, 0, 1, 512, 0);
    checks++;
    if (lft_spd !== 12'sd576 || rght_spd !== 12'sd448) begin
      failures++;
      $display("FAIL mixing got=%0d/%0d exp=576/448", lft_spd, rght_spd);
    end
    cycle(0, 0, 1, 1000, -800);
    cycle(0, 0, 1, 1000, -800);
    checks++;
    if (lft_spd !== 12'sd900 || rght_spd !== 12'sd1100) begin
      failures++;
      $display("FAIL dterm got=%0d/%0d exp=900/1100", lft_spd, rght_spd);
    end
  endtask

  task automatic test_out_sat_stop();
    cycle(511, 0, 1, 2047, 0);
    cycle(511, 0, 1, 2047, 0);
    checks++;
    if (lft_spd !== 12'sh7FF || rght_spd !== 12'sd1536) begin
      failures++;
      $display("FAIL out_sat got=%0d/%0d exp=2047/1536", lft_spd, rght_spd);
    end
    cycle(511, 0, 0, 2047, 0);
    cycle(511, 0, 0, 2047, 0);
    checks++;
    if (lft_spd !== 12'sd0 || rght_spd !== 12'sd0) begin
      failures++;
      $display("FAIL stop got=%0d/%0d exp=0/0", lft_spd, rght_spd);
    end
    cycle(0, 0, 1, 1024, 0);
    cycle(0, 0, 1, 1024, 0);
    checks++;
    if (lft_spd !== 12'sd1024 || rght_spd !== 12'sd1024) begin
      failures++;
      $display("FAIL stop_integ_clear got=%0d/%0d exp=1024/1024", lft_spd, rght_spd);
    end
  endtask

  task automatic test_back_to_back();
    int e, fs, d;
    bit vld, mov;
    for (int i = 0; i < 40; i++) begin
      e   = int'($urandom_range(0, 4095)) - 2048;
      fs  = int'($urandom_range(0, 2047));
      d   = int'($urandom_range(0, 8191)) - 4096;
      vld = ($urandom_range(0, 3) != 0);
      mov = ($urandom_range(0, 7) != 0);
      cycle(e, vld, mov, fs, d);
    end
  endtask

  initial begin
    test_reset();
    test_saturation();
    test_integration();
    test_reset_mid();
    test_overflow();
    test_mixing();
    test_out_sat_stop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
